lab7_q2_a_m: RTL and testbench

LAB7_Q2_A_M -- requirements
Module: lab7_q2_a_m

---
 rtl/lab7_q2_a_m.sv | 34 +++
 tb/tb_lab7_q2_a_m.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lab7_q2_a_m.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// x0 is hard-wired to zero; reset loads every register with its own index.
module lab7_q2_a_m (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] rd_data,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    logic [31:0] r_regs [0:31];
    logic        w_wr_en;

    assign w_wr_en = we && (rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'(i);
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= rd_data;
        end
    end

    // No write bypass: reads always see the stored value, x0 forced to zero.
    assign rs1_data = (rs1 == 5'd0) ? 32'h0000_0000 : r_regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'h0000_0000 : r_regs[rs2];

endmodule

// File: tb/tb_lab7_q2_a_m.sv
// Self-checking bench for lab7_q2_a_m: reset sweep, directed vector table,
// async-reset corner cases and randomized traffic against an array model.
module tb_lab7_q2_a_m;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [0:31];

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pre1;
        logic [31:0] pre2;
        logic [31:0] post1;
        logic [31:0] post2;
    } vec_t;

    vec_t vecs [0:4];

    lab7_q2_a_m dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .rd       (rd),
        .rd_data  (rd_data),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = i;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : mdl[a];
    endfunction

    initial begin
        vecs[0] = '{1'b1, 5'd4,  32'hDEADBEEF, 5'd5,  5'd4,
                    32'h5, 32'h4, 32'h5, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd4,
                    32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31,
                    32'h1F, 32'h1F, 32'h12345678, 32'h12345678};
        vecs[3] = '{1'b0, 5'd31, 32'hAAAAAAAA, 5'd31, 5'd31,
                    32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[4] = '{1'b0, 5'd4,  32'h00000000, 5'd4,  5'd31,
                    32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};

        rst = 1'b1; we = 1'b0; rd = '0; rd_data = '0; rs1 = 5'd1; rs2 = 5'd31;
        #1;
        chk("rst_hold_rs1", rs1_data, 32'h1);
        chk("rst_hold_rs2", rs2_data, 32'h1F);

        // Reset read sweep, released between clock edges.
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rs1 = 5'(k);
            rs2 = 5'(k + 4);
            #1;
            chk($sformatf("sweep_rs1_%0d", k), rs1_data, 32'(k));
            chk($sformatf("sweep_rs2_%0d", k), rs2_data, 32'(k + 4));
            #9;
        end

        // Directed table: pre-edge values show no bypass, post-edge the write.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            we = vecs[v].we; rd = vecs[v].rd; rd_data = vecs[v].wdata;
            rs1 = vecs[v].rs1; rs2 = vecs[v].rs2;
            #1;
            chk($sformatf("vec%0d_pre_rs1", v), rs1_data, vecs[v].pre1);
            chk($sformatf("vec%0d_pre_rs2", v), rs2_data, vecs[v].pre2);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_post_rs1", v), rs1_data, vecs[v].post1);
            chk($sformatf("vec%0d_post_rs2", v), rs2_data, vecs[v].post2);
        end

        // Async reset between edges restores init values immediately.
        @(negedge clk);
        we = 1'b0; rs1 = 5'd4; rs2 = 5'd31;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rs1", rs1_data, 32'h4);
        chk("async_rst_rs2", rs2_data, 32'h1F);

        // Writes are blocked while reset is held across an edge.
        we = 1'b1; rd = 5'd4; rd_data = 32'h55;
        @(posedge clk);
        #1;
        chk("wr_blocked_in_rst", rs1_data, 32'h4);

        // First write after release lands on the next edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rel_pre", rs1_data, 32'h4);
        @(posedge clk);
        #1;
        chk("after_rel_post", rs1_data, 32'h55);
        chk("after_rel_other", rs2_data, 32'h1F);

        // Randomized traffic against the array model.
        @(negedge clk);
        we = 1'b0;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic       pulse;
            logic       t_we;
            logic [4:0] t_rd;
            logic [31:0] t_d;
            @(negedge clk);
            t_we = 1'($urandom_range(0, 3) != 0);
            t_rd = 5'($urandom_range(0, 31));
            t_d  = $urandom;
            we = t_we; rd = t_rd; rd_data = t_d;
            rs1 = 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, 31));
            pulse = ($urandom_range(0, 39) == 0);
            #1;
            chk("rand_rs1", rs1_data, model_read(rs1));
            chk("rand_rs2", rs2_data, model_read(rs2));
            if (pulse) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
                chk("rand_rst_rs1", rs1_data, model_read(rs1));
            end
            @(posedge clk);
            if (t_we && t_rd != 5'd0) mdl[t_rd] = t_d;
            #1;
            chk("rand_post_rs1", rs1_data, model_read(rs1));
            chk("rand_post_rs2", rs2_data, model_read(rs2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
